cmd_processor_v2: RTL and testbench

CMD_PROCESSOR_V2 -- requirements
Module: cmd_processor_v2

---
 rtl/cmd_pkg.sv | 29 ++
 rtl/cmd_processor_v2_tx_byte_seq.sv | 38 +++
 rtl/cmd_processor_v2.sv | 186 ++++++++++++++++++
 tb/tb_cmd_processor_v2.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared opcodes, NAK byte and controller state encoding for the byte-command processor.
package cmd_pkg;

    localparam logic [7:0] OP_VERSION = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_TOGGLE  = 8'h03;
    localparam logic [7:0] OP_DUMP    = 8'h0A;
    localparam logic [7:0] NAK_BYTE   = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        ARGS,
        EXEC,
        HFETCH,
        HLOAD,
        TXWAIT,
        TXSTROBE
    } state_t;

    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            OP_WRITE, OP_TOGGLE: return 2'd2;
            OP_READ:             return 2'd1;
            default:             return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_processor_v2_tx_byte_seq.sv
// Single-byte handshake toward the UART: waits for an idle transmitter, presents the
// byte and strobes tx_start for one cycle, then masks tx_busy for the following cycle.
module tx_byte_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wait,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic       o_fire,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data
);

    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       r_guard;
    logic       w_fire;

    // The UART raises busy a cycle late, so the cycle after the strobe cannot be trusted.
    assign w_fire     = i_wait && !i_tx_busy && !r_guard;
    assign o_fire     = w_fire;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'd0;
            r_guard    <= 1'b0;
        end else begin
            r_tx_start <= w_fire;
            r_guard    <= r_tx_start;
            if (w_fire)
                r_tx_data <= i_byte;
        end
    end

endmodule

// File: rtl/cmd_processor_v2.sv
// Byte-command processor: register file access, firmware version query and a
// histogram dump serialised LSB-first over a UART transmitter.
module cmd_processor_v2
    import cmd_pkg::*;
#(
    parameter int                NREG        = 16,
    parameter int                HIST_N      = 72,
    parameter int                TIMEOUT_CYC = 50_000_000,
    parameter int                FW_VERSION  = 15,
    parameter logic [NREG*8-1:0] CFG_RESET   = '0,
    localparam int               HAW         = (HIST_N > 1) ? $clog2(HIST_N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [NREG*8-1:0] cfg_regs,
    output logic [NREG-1:0]   cfg_update,
    output logic [HAW-1:0]    hist_addr,
    output logic              hist_rd,
    input  logic [31:0]       hist_data,
    output logic              hist_reset
);

    localparam int          IDXW     = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [31:0] NAK_WORD = {24'd0, NAK_BYTE};
    localparam logic [31:0] FW_WORD  = {24'd0, 8'(FW_VERSION)};

    state_t                r_state;
    logic [7:0]            r_opcode;
    logic [7:0]            r_arg0;
    logic [7:0]            r_arg1;
    logic [1:0]            r_nargs;
    logic [1:0]            r_arg_cnt;
    logic [31:0]           r_tmo;
    logic [31:0]           r_word;
    logic [1:0]            r_byte_sel;
    logic                  r_dump;
    logic [NREG-1:0][7:0]  r_regs;
    logic [NREG-1:0]       r_cfg_update;
    logic [HAW-1:0]        r_hist_addr;
    logic                  r_hist_rd;
    logic                  r_hist_reset;

    logic                  w_fire;
    logic                  w_idx_ok;
    logic [IDXW-1:0]       w_idx;

    assign w_idx_ok   = {24'd0, r_arg0} < 32'(NREG);
    assign w_idx      = r_arg0[IDXW-1:0];

    assign cfg_regs   = r_regs;
    assign cfg_update = r_cfg_update;
    assign hist_addr  = r_hist_addr;
    assign hist_rd    = r_hist_rd;
    assign hist_reset = r_hist_reset;

    tx_byte_seq u_tx_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wait     (r_state == TXWAIT),
        .i_byte     (r_word[7:0]),
        .i_tx_busy  (tx_busy),
        .o_fire     (w_fire),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_opcode     <= 8'd0;
            r_arg0       <= 8'd0;
            r_arg1       <= 8'd0;
            r_nargs      <= 2'd0;
            r_arg_cnt    <= 2'd0;
            r_tmo        <= 32'd0;
            r_word       <= 32'd0;
            r_byte_sel   <= 2'd0;
            r_dump       <= 1'b0;
            r_regs       <= CFG_RESET;
            r_cfg_update <= '0;
            r_hist_addr  <= '0;
            r_hist_rd    <= 1'b0;
            r_hist_reset <= 1'b0;
        end else begin
            r_cfg_update <= '0;
            r_hist_rd    <= 1'b0;
            r_hist_reset <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rx_ready) begin
                        r_opcode  <= rx_data;
                        r_nargs   <= arg_count(rx_data);
                        r_arg_cnt <= 2'd0;
                        r_tmo     <= 32'd0;
                        r_state   <= (arg_count(rx_data) == 2'd0) ? EXEC : ARGS;
                    end
                end
                ARGS: begin
                    if (rx_ready) begin
                        r_tmo <= 32'd0;
                        if (r_arg_cnt == 2'd0)
                            r_arg0 <= rx_data;
                        else
                            r_arg1 <= rx_data;
                        r_arg_cnt <= r_arg_cnt + 2'd1;
                        if (r_arg_cnt + 2'd1 == r_nargs)
                            r_state <= EXEC;
                    end else if (r_tmo == 32'(TIMEOUT_CYC - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
                EXEC: begin
                    r_dump     <= 1'b0;
                    r_byte_sel <= 2'd0;
                    r_word     <= NAK_WORD;
                    r_state    <= TXWAIT;
                    case (r_opcode)
                        OP_VERSION: r_word <= FW_WORD;
                        OP_WRITE: begin
                            if (w_idx_ok) begin
                                r_regs[w_idx]       <= r_arg1;
                                r_cfg_update[w_idx] <= 1'b1;
                                r_state             <= IDLE;
                            end
                        end
                        OP_READ: begin
                            if (w_idx_ok)
                                r_word <= {24'd0, r_regs[w_idx]};
                        end
                        OP_TOGGLE: begin
                            if (w_idx_ok) begin
                                r_regs[w_idx]       <= r_regs[w_idx] ^ (8'd1 << r_arg1[2:0]);
                                r_cfg_update[w_idx] <= 1'b1;
                                r_state             <= IDLE;
                            end
                        end
                        OP_DUMP: begin
                            r_dump      <= 1'b1;
                            r_hist_addr <= '0;
                            r_hist_rd   <= 1'b1;
                            r_state     <= HFETCH;
                        end
                        default: ;
                    endcase
                end
                HFETCH: r_state <= HLOAD;
                HLOAD: begin
                    r_word     <= hist_data;
                    r_byte_sel <= 2'd0;
                    r_state    <= TXWAIT;
                end
                TXWAIT: begin
                    if (w_fire)
                        r_state <= TXSTROBE;
                end
                TXSTROBE: begin
                    if (!r_dump) begin
                        r_state <= IDLE;
                    end else if (r_byte_sel != 2'd3) begin
                        r_byte_sel <= r_byte_sel + 2'd1;
                        r_word     <= r_word >> 8;
                        r_state    <= TXWAIT;
                    end else if (r_hist_addr == HAW'(HIST_N - 1)) begin
                        // Last byte of the last word: release the source for a fresh accumulation.
                        r_hist_reset <= 1'b1;
                        r_dump       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_hist_addr <= r_hist_addr + 1'b1;
                        r_hist_rd   <= 1'b1;
                        r_state     <= HFETCH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_processor_v2.sv
// Directed bench for cmd_processor_v2: UART and histogram source models plus per-feature tasks.
module tb_cmd_processor_v2;

    localparam int NREG   = 16;
    localparam int HIST_N = 72;
    localparam int TMO    = 100;
    localparam int FW     = 15;
    localparam logic [NREG*8-1:0] CFG_INIT = 128'h1F1E1D1C1B1A19181716151413121110;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_ready = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              tx_busy = 1'b0;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [NREG*8-1:0] cfg_regs;
    logic [NREG-1:0]   cfg_update;
    logic [6:0]        hist_addr;
    logic              hist_rd;
    logic [31:0]       hist_data = 32'd0;
    logic              hist_reset;

    int errors = 0;
    int checks = 0;

    cmd_processor_v2 #(
        .NREG(NREG), .HIST_N(HIST_N), .TIMEOUT_CYC(TMO), .FW_VERSION(FW), .CFG_RESET(CFG_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .cfg_regs(cfg_regs), .cfg_update(cfg_update),
        .hist_addr(hist_addr), .hist_rd(hist_rd), .hist_data(hist_data), .hist_reset(hist_reset)
    );

    always #5 clk = ~clk;

    // UART / histogram models, sampled on the falling edge
    logic [7:0]      txq[$];
    logic [NREG-1:0] updq[$];
    int cyc = 0, last_tx_cyc = -10, hr_cnt = 0, hr_cyc = -1, overrun = 0;
    int rd_cnt = 0, max_addr = 0, busy_left = 0;
    logic pend1 = 1'b0, pend2 = 1'b0, rd_pend = 1'b0;
    logic [6:0] rd_addr = 7'd0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_start) begin
            if (pend1 || pend2 || tx_busy) overrun <= overrun + 1;
            txq.push_back(tx_data);
            last_tx_cyc <= cyc;
        end
        pend1 <= tx_start;
        pend2 <= pend1;
        if (pend2) begin
            tx_busy   <= 1'b1;
            busy_left <= $urandom_range(1, 3);
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
        if (cfg_update != '0) updq.push_back(cfg_update);
        if (hist_reset) begin
            hr_cnt <= hr_cnt + 1;
            hr_cyc <= cyc;
        end
        if (hist_rd) begin
            rd_cnt <= rd_cnt + 1;
            if (int'(hist_addr) > max_addr) max_addr <= int'(hist_addr);
        end
        rd_pend   <= hist_rd;
        rd_addr   <= hist_addr;
        hist_data <= rd_pend ? (32'h04030201 + 32'(rd_addr)) : 32'hDEADBEEF;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] txb(input int i);
        return (i < txq.size()) ? txq[i] : 8'bx;
    endfunction

    function automatic logic [NREG-1:0] updb(input int i);
        return (i < updq.size()) ? updq[i] : {NREG{1'bx}};
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'd0;
        @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int bound, output bit ok);
        int c = 0;
        while (txq.size() < n && c < bound) begin
            @(negedge clk);
            c++;
        end
        ok = (txq.size() >= n);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (cfg_regs !== CFG_INIT) begin errors++; $display("FAIL reset_cfg_regs: got %h want %h", cfg_regs, CFG_INIT); end
        checks++; if (cfg_update !== '0) begin errors++; $display("FAIL reset_cfg_update: got %h want 0", cfg_update); end
        checks++; if ({hist_rd, hist_reset, hist_addr} !== 9'd0) begin errors++;
            $display("FAIL reset_hist: got rd=%b rst=%b addr=%0d want 0", hist_rd, hist_reset, hist_addr); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_version();
        int b0 = txq.size();
        bit ok;
        send(8'h00);
        wait_tx(b0 + 1, 100, ok);
        repeat (20) @(negedge clk);
        checks++; if (txq.size() - b0 != 1) begin errors++; $display("FAIL version_count: got %0d want 1", txq.size() - b0); end
        checks++; if (txb(b0) !== 8'h0F) begin errors++; $display("FAIL version_byte: got %h want 0f", txb(b0)); end
    endtask

    task automatic test_write_read(inout logic [NREG*8-1:0] exp);
        int b0 = txq.size();
        int u0 = updq.size();
        bit ok;
        send(8'h01); send(8'h03); send(8'h5A);
        repeat (10) @(negedge clk);
        exp[31:24] = 8'h5A;
        checks++; if (cfg_regs !== exp) begin errors++; $display("FAIL write_regs: got %h want %h", cfg_regs, exp); end
        checks++; if (updq.size() - u0 != 1) begin errors++; $display("FAIL write_upd_count: got %0d want 1", updq.size() - u0); end
        checks++; if (updb(u0) !== 16'h0008) begin errors++; $display("FAIL write_upd_value: got %h want 0008", updb(u0)); end
        checks++; if (txq.size() != b0) begin errors++; $display("FAIL write_no_tx: got %0d bytes want 0", txq.size() - b0); end
        send(8'h02); send(8'h03);
        wait_tx(b0 + 1, 100, ok);
        repeat (20) @(negedge clk);
        checks++; if (txq.size() - b0 != 1) begin errors++; $display("FAIL read_count: got %0d want 1", txq.size() - b0); end
        checks++; if (txb(b0) !== 8'h5A) begin errors++; $display("FAIL read_byte: got %h want 5a", txb(b0)); end
    endtask

    task automatic test_toggle_nak(inout logic [NREG*8-1:0] exp);
        logic [7:0] cmd [4][3];
        int         len [4];
        int b0 = txq.size();
        int u0 = updq.size();
        bit ok;
        send(8'h03); send(8'h03); send(8'h09);
        send(8'h03); send(8'h0F); send(8'h0F);
        repeat (10) @(negedge clk);
        exp[31:24]   = 8'h58;
        exp[127:120] = 8'h9F;
        checks++; if (cfg_regs !== exp) begin errors++; $display("FAIL toggle_regs: got %h want %h", cfg_regs, exp); end
        checks++; if (updq.size() - u0 != 2 || updb(u0) !== 16'h0008 || updb(u0 + 1) !== 16'h8000) begin errors++;
            $display("FAIL toggle_upd: got n=%0d %h %h want 2 0008 8000", updq.size() - u0, updb(u0), updb(u0 + 1)); end
        checks++; if (txq.size() != b0) begin errors++; $display("FAIL toggle_no_tx: got %0d bytes want 0", txq.size() - b0); end
        // write idx 0x20, read idx 0x10 (=NREG), toggle idx 0x10, unknown opcode 0x55
        cmd[0] = '{8'h01, 8'h20, 8'h11}; len[0] = 3;
        cmd[1] = '{8'h02, 8'h10, 8'h00}; len[1] = 2;
        cmd[2] = '{8'h03, 8'h10, 8'h00}; len[2] = 3;
        cmd[3] = '{8'h55, 8'h00, 8'h00}; len[3] = 1;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < len[c]; j++) send(cmd[c][j]);
            wait_tx(b0 + c + 1, 100, ok);
            repeat (15) @(negedge clk);
            checks++; if (txb(b0 + c) !== 8'hEE) begin errors++; $display("FAIL nak_%0d: got %h want ee", c, txb(b0 + c)); end
        end
        checks++; if (txq.size() - b0 != 4) begin errors++; $display("FAIL nak_count: got %0d want 4", txq.size() - b0); end
        checks++; if (cfg_regs !== exp) begin errors++; $display("FAIL nak_regs: got %h want %h", cfg_regs, exp); end
        checks++; if (updq.size() - u0 != 2) begin errors++; $display("FAIL nak_upd: got %0d pulses want 2", updq.size() - u0); end
    endtask

    task automatic test_dump();
        logic [7:0]  head [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h02, 8'h03, 8'h04};
        logic [31:0] w;
        int b0 = txq.size(), hr0 = hr_cnt, rd0 = rd_cnt, ov0 = overrun, bad = 0;
        bit ok;
        send(8'h0A);
        wait_tx(b0 + 4 * HIST_N, 20000, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL dump_timeout: got %0d bytes want %0d", txq.size() - b0, 4 * HIST_N); end
        checks++; if (txq.size() - b0 != 4 * HIST_N) begin errors++; $display("FAIL dump_count: got %0d want %0d", txq.size() - b0, 4 * HIST_N); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (txb(b0 + i) !== head[i]) begin errors++; $display("FAIL dump_head_%0d: got %h want %h", i, txb(b0 + i), head[i]); end
        end
        for (int k = 0; k < HIST_N; k++) begin
            w = 32'h04030201 + 32'(k);
            for (int j = 0; j < 4; j++) if (txb(b0 + 4 * k + j) !== w[8 * j +: 8]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL dump_bytes: got %0d wrong bytes want 0", bad); end
        checks++; if (hr_cnt - hr0 != 1) begin errors++; $display("FAIL dump_hreset_count: got %0d want 1", hr_cnt - hr0); end
        checks++; if (hr_cyc != last_tx_cyc + 1) begin errors++; $display("FAIL dump_hreset_time: got cyc %0d want %0d", hr_cyc, last_tx_cyc + 1); end
        checks++; if (rd_cnt - rd0 != HIST_N) begin errors++; $display("FAIL dump_reads: got %0d want %0d", rd_cnt - rd0, HIST_N); end
        checks++; if (max_addr != HIST_N - 1) begin errors++; $display("FAIL dump_max_addr: got %0d want %0d", max_addr, HIST_N - 1); end
        checks++; if (overrun != ov0) begin errors++; $display("FAIL dump_overrun: got %0d want 0", overrun - ov0); end
    endtask

    task automatic test_timeout(inout logic [NREG*8-1:0] exp);
        int b0 = txq.size();
        int u0;
        bit ok;
        // 99 idle cycles: still inside the window, write completes
        send(8'h01); send(8'h02);
        repeat (98) @(negedge clk);
        send(8'h33);
        repeat (10) @(negedge clk);
        exp[23:16] = 8'h33;
        checks++; if (cfg_regs !== exp) begin errors++; $display("FAIL tmo_99_regs: got %h want %h", cfg_regs, exp); end
        u0 = updq.size();
        // 100 idle cycles: command dropped, next byte is a fresh opcode
        send(8'h01); send(8'h02);
        repeat (99) @(negedge clk);
        send(8'h00);
        wait_tx(b0 + 1, 100, ok);
        repeat (20) @(negedge clk);
        checks++; if (cfg_regs !== exp) begin errors++; $display("FAIL tmo_100_regs: got %h want %h", cfg_regs, exp); end
        checks++; if (updq.size() != u0) begin errors++; $display("FAIL tmo_100_upd: got %0d pulses want 0", updq.size() - u0); end
        checks++; if (txq.size() - b0 != 1 || txb(b0) !== 8'h0F) begin errors++;
            $display("FAIL tmo_100_version: got n=%0d %h want 1 0f", txq.size() - b0, txb(b0)); end
    endtask

    task automatic test_back_to_back();
        int b0 = txq.size();
        bit ok;
        send(8'h00);
        send(8'h02);   // arrives while the reply is pending; must be dropped
        wait_tx(b0 + 1, 100, ok);
        repeat (20) @(negedge clk);
        send(8'h02); send(8'h01);
        wait_tx(b0 + 2, 100, ok);
        repeat (20) @(negedge clk);
        checks++; if (txq.size() - b0 != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", txq.size() - b0); end
        checks++; if (txb(b0) !== 8'h0F || txb(b0 + 1) !== 8'h11) begin errors++;
            $display("FAIL b2b_bytes: got %h %h want 0f 11", txb(b0), txb(b0 + 1)); end
    endtask

    task automatic test_reset_mid_dump();
        int b0 = txq.size(), b1, hr0;
        bit ok;
        send(8'h0A);
        wait_tx(b0 + 50, 2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rdump_reach50: got %0d bytes want 50", txq.size() - b0); end
        rst_n = 1'b0;
        @(negedge clk);
        b1  = txq.size();
        hr0 = hr_cnt;
        repeat (4) @(negedge clk);
        checks++; if (cfg_regs !== CFG_INIT) begin errors++; $display("FAIL rdump_regs: got %h want %h", cfg_regs, CFG_INIT); end
        checks++; if (hist_addr !== 7'd0 || hist_rd !== 1'b0) begin errors++;
            $display("FAIL rdump_hist: got addr=%0d rd=%b want 0 0", hist_addr, hist_rd); end
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++; if (txq.size() != b1) begin errors++; $display("FAIL rdump_no_tx: got %0d bytes want 0", txq.size() - b1); end
        checks++; if (hr_cnt != hr0) begin errors++; $display("FAIL rdump_no_hreset: got %0d want 0", hr_cnt - hr0); end
        send(8'h00);
        wait_tx(b1 + 1, 100, ok);
        repeat (10) @(negedge clk);
        checks++; if (txq.size() - b1 != 1 || txb(b1) !== 8'h0F) begin errors++;
            $display("FAIL rdump_version: got n=%0d %h want 1 0f", txq.size() - b1, txb(b1)); end
    endtask

    initial begin
        logic [NREG*8-1:0] exp;
        exp = CFG_INIT;
        @(negedge clk);
        test_reset();
        test_version();
        test_write_read(exp);
        test_toggle_nak(exp);
        test_dump();
        test_timeout(exp);
        test_back_to_back();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
